// File: rtl/clk_div.sv
// Parameterised clock divider: produces a 50 % duty-cycle sck from clk plus
// registered single-cycle rise/fall strobes in the clk domain.
module clk_div #(
  parameter int unsigned HALF_PERIOD = 13_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  // One bit minimum so HALF_PERIOD = 1 still has a legal counter.
  localparam int unsigned    CNT_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("clk_div: HALF_PERIOD must be >= 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             wrap;

  // Wrap is an explicit compare so non-power-of-2 periods never overflow.
  // NOTE: every always_comb output gets a value on every path (here via the
  // unconditional assignments), otherwise synthesis infers a latch.
  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    sck_d  = wrap ? ~sck_q : sck_q;
    rise_d = wrap & ~sck_q;
    fall_d = wrap &  sck_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sck      = sck_q;
  assign sck_rise = rise_q;
  assign sck_fall = fall_q;

endmodule

// File: tb/tb_clk_div.sv
// Scoreboard bench for clk_div: four instances (HALF_PERIOD 1, 4, 5, 6) under
// directed and random resets, compared against an edge-count reference model.
module tb_clk_div;

  logic       clk = 1'b0;
  logic [3:0] rst_v = 4'hF;
  logic [3:0] sck_v, rise_v, fall_v;

  always #5 clk = ~clk;

  clk_div #(.HALF_PERIOD(1)) u_hp1 (.clk(clk), .rst(rst_v[0]), .sck(sck_v[0]), .sck_rise(rise_v[0]), .sck_fall(fall_v[0]));
  clk_div #(.HALF_PERIOD(4)) u_hp4 (.clk(clk), .rst(rst_v[1]), .sck(sck_v[1]), .sck_rise(rise_v[1]), .sck_fall(fall_v[1]));
  clk_div #(.HALF_PERIOD(5)) u_hp5 (.clk(clk), .rst(rst_v[2]), .sck(sck_v[2]), .sck_rise(rise_v[2]), .sck_fall(fall_v[2]));
  clk_div #(.HALF_PERIOD(6)) u_hp6 (.clk(clk), .rst(rst_v[3]), .sck(sck_v[3]), .sck_rise(rise_v[3]), .sck_fall(fall_v[3]));

  typedef struct packed {
    logic [3:0] sck;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int unsigned hp_of(int i);
    case (i)
      0:       return 1;
      1:       return 4;
      2:       return 5;
      default: return 6;
    endcase
  endfunction

  // Reference: after k non-reset edges sck = floor(k/HP) mod 2, and a strobe
  // fires exactly on the edges where k is a nonzero multiple of HP.
  function automatic logic [2:0] model(int unsigned k, int unsigned hp);
    logic s, e;
    s = ((k / hp) % 2) == 1;
    e = (k > 0) && ((k % hp) == 0);
    return {s, e & s, e & ~s};
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every clk edge the DUTs present new outputs; compare after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sck[hp=%0d]", hp_of(i)),  int'(sck_v[i]),  int'(e.sck[i]));
        check($sformatf("rise[hp=%0d]", hp_of(i)), int'(rise_v[i]), int'(e.rise[i]));
        check($sformatf("fall[hp=%0d]", hp_of(i)), int'(fall_v[i]), int'(e.fall[i]));
      end
    end
  end

  int unsigned k [4] = '{0, 0, 0, 0};
  bit          mid_done = 1'b0;

  // Drive rst for the next edge and push what every instance must show after it.
  task automatic step(input logic [3:0] r);
    exp_t       e;
    logic [2:0] m;
    @(negedge clk);
    rst_v = r;
    for (int i = 0; i < 4; i++) begin
      k[i] = r[i] ? 0 : k[i] + 1;
      m = model(k[i], hp_of(i));
      e.sck[i]  = m[2];
      e.rise[i] = m[1];
      e.fall[i] = m[0];
    end
    q.push_back(e);
  endtask

  initial begin
    logic [3:0] r;
    // Three reset cycles on every instance.
    for (int c = 0; c < 3; c++) step(4'hF);
    // Long reset-free run; HP=5 gets one reset pulse while sck=1 and cnt=2.
    for (int c = 0; c < 130; c++) begin
      r = 4'h0;
      if (!mid_done && k[2] == 7) begin
        r[2]     = 1'b1;
        mid_done = 1'b1;
      end
      step(r);
    end
    // Random resets, roughly one per 40 cycles per instance.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 39) == 0);
      step(r);
    end
    step(4'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_reset_applied", int'(mid_done), 1);
    check("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
